// File: rtl/core_pkg.sv
// Shared core-wide constants and the physical-register tag type.
package core_pkg;
  localparam int PRF_DATA_W    = 32;
  localparam int PRF_NUM_PREGS = 128;
  localparam int PRF_TAG_W     = $clog2(PRF_NUM_PREGS);

  typedef logic [PRF_TAG_W-1:0] ptag_t;
endpackage

// File: rtl/prf_scoreboard.sv
// Ready-bit scoreboard for the physical register file: alloc clears, writeback
// sets, flush sets all; queries see same-cycle writebacks.
module prf_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_PREGS = PRF_NUM_PREGS,
  parameter int NUM_RD    = 6,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1,
  parameter int TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*TAG_W-1:0]    wr_tag,
  input  logic [NUM_ALLOC-1:0]       alloc_en,
  input  logic [NUM_ALLOC*TAG_W-1:0] alloc_tag,
  input  logic                       flush,
  input  logic [NUM_RD*TAG_W-1:0]    rdy_tag,
  output logic [NUM_RD-1:0]          rdy
);

  logic [NUM_PREGS-1:0] rdy_q;
  logic [NUM_PREGS-1:0] rdy_d;

  // Writebacks set first, allocates then clear so allocate wins a collision;
  // flush overrides both. Tag 0 is never cleared.
  always_comb begin
    rdy_d = rdy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) rdy_d[wr_tag[w*TAG_W +: TAG_W]] = 1'b1;
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_en[a] && (alloc_tag[a*TAG_W +: TAG_W] != '0))
        rdy_d[alloc_tag[a*TAG_W +: TAG_W]] = 1'b0;
    end
    if (flush) rdy_d = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdy_q <= '1;
    else       rdy_q <= rdy_d;
  end

  always_comb begin
    rdy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rdy[r] = rdy_q[rdy_tag[r*TAG_W +: TAG_W]] || (rdy_tag[r*TAG_W +: TAG_W] == '0);
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_tag[w*TAG_W +: TAG_W] == rdy_tag[r*TAG_W +: TAG_W]))
          rdy[r] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// Multiported physical register file with write-to-read bypass, registered
// reads, hardwired-zero tag 0 and an attached ready-bit scoreboard.
module prf_multiport
  import core_pkg::*;
#(
  parameter int DATA_W    = PRF_DATA_W,
  parameter int NUM_PREGS = PRF_NUM_PREGS,
  parameter int NUM_RD    = 6,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_WR-1:0]                         wr_en,
  input  logic [NUM_WR*$clog2(NUM_PREGS)-1:0]       wr_tag,
  input  logic [NUM_WR*DATA_W-1:0]                  wr_data,
  input  logic [NUM_RD-1:0]                         rd_en,
  input  logic [NUM_RD*$clog2(NUM_PREGS)-1:0]       rd_tag,
  output logic [NUM_RD*DATA_W-1:0]                  rd_data,
  input  logic [NUM_ALLOC-1:0]                      alloc_en,
  input  logic [NUM_ALLOC*$clog2(NUM_PREGS)-1:0]    alloc_tag,
  input  logic                                      flush,
  input  logic [NUM_RD*$clog2(NUM_PREGS)-1:0]       rdy_tag,
  output logic [NUM_RD-1:0]                         rdy,
  output logic                                      wr_conflict
);

  localparam int TAG_W = $clog2(NUM_PREGS);

  logic [DATA_W-1:0]        mem [NUM_PREGS];
  logic [DATA_W-1:0]        rd_byp_p0 [NUM_RD];
  logic                     conflict_p0;
  logic [NUM_RD*DATA_W-1:0] rd_data_p1;
  logic                     wr_conflict_q;

  // Stage p0: same-tag write collisions and bypassed read values.
  always_comb begin
    conflict_p0 = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wr_en[a] && wr_en[b] &&
            (wr_tag[a*TAG_W +: TAG_W] == wr_tag[b*TAG_W +: TAG_W]) &&
            (wr_tag[a*TAG_W +: TAG_W] != '0))
          conflict_p0 = 1'b1;
      end
    end
  end

  // Later write ports override earlier ones, matching the array update order.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_byp_p0[r] = (rd_tag[r*TAG_W +: TAG_W] == '0) ? '0 : mem[rd_tag[r*TAG_W +: TAG_W]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_tag[w*TAG_W +: TAG_W] == rd_tag[r*TAG_W +: TAG_W]) &&
            (rd_tag[r*TAG_W +: TAG_W] != '0))
          rd_byp_p0[r] = wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) mem[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_tag[w*TAG_W +: TAG_W] != '0))
          mem[wr_tag[w*TAG_W +: TAG_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: registered read data and sticky conflict flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_p1    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en[r]) rd_data_p1[r*DATA_W +: DATA_W] <= rd_byp_p0[r];
      end
      if (conflict_p0) wr_conflict_q <= 1'b1;
    end
  end

  assign rd_data     = rd_data_p1;
  assign wr_conflict = wr_conflict_q;

  prf_scoreboard #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC),
    .TAG_W     (TAG_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_tag    (wr_tag),
    .alloc_en  (alloc_en),
    .alloc_tag (alloc_tag),
    .flush     (flush),
    .rdy_tag   (rdy_tag),
    .rdy       (rdy)
  );

endmodule

// File: doc/prf_multiport.md
PRF_MULTIPORT -- requirements
Module: prf_multiport

Interface
REQ-001 SHALL take parameter DATA_W, 32, register data width.
REQ-002 SHALL take parameter NUM_PREGS, 128, number of physical registers; power of two, at least 8.
REQ-003 SHALL take parameter NUM_RD, 6, number of read ports.
REQ-004 SHALL take parameter NUM_WR, 2, number of write (writeback) ports.
REQ-005 SHALL take parameter NUM_ALLOC, 1, number of allocate (rename) ports.
REQ-006 SHALL derive TAG_W = clog2(NUM_PREGS) as a local parameter.
REQ-007 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-008 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port wr_en  input  NUM_WR  per-port write strobe.
REQ-010 SHALL have port wr_tag  input  NUM_WR*TAG_W  per-port destination tag.
REQ-011 SHALL have port wr_data  input  NUM_WR*DATA_W  per-port write data.
REQ-012 SHALL have port rd_en  input  NUM_RD  per-port read strobe.
REQ-013 SHALL have port rd_tag  input  NUM_RD*TAG_W  per-port source tag.
REQ-014 SHALL have port rd_data  output  NUM_RD*DATA_W  per-port registered read data.
REQ-015 SHALL have port alloc_en  input  NUM_ALLOC  rename allocation strobe.
REQ-016 SHALL have port alloc_tag  input  NUM_ALLOC*TAG_W  newly allocated destination tag.
REQ-017 SHALL have port flush  input  1  mispredict squash.
REQ-018 SHALL have port rdy_tag  input  NUM_RD*TAG_W  scoreboard query tags.
REQ-019 SHALL have port rdy  output  NUM_RD  combinational ready bit of rdy_tag.
REQ-020 SHALL have port wr_conflict  output  1  sticky error flag.

Function
REQ-021 SHALL provide read latency of exactly 1 cycle: rd_data[i] updates at the edge where rd_en[i]=1.
REQ-022 SHALL hold rd_data[i] unchanged in cycles where rd_en[i]=0.
REQ-023 SHALL bypass writes to reads: a read and a write to the same tag in the same cycle return the new write data.
REQ-024 SHALL treat tag 0 as hardwired zero: writes are ignored, reads return 0, and rdy is always 1.
REQ-025 SHALL resolve same-cycle writes to one tag so that the highest-index write port wins, including on the bypass path, and SHALL set wr_conflict.
REQ-026 SHALL keep wr_conflict set until reset.
REQ-027 SHALL clear the ready bit of alloc_tag at the edge where alloc_en=1.
REQ-028 SHALL set the ready bit of wr_tag at the edge where wr_en=1.
REQ-029 SHALL give allocate priority when an allocate and a write hit the same tag in one cycle: the ready bit ends at 0 and the data is still written.
REQ-030 SHALL report rdy combinationally, including same-cycle writeback: rdy=1 if the stored bit is 1 or any wr_en targets the tag that cycle.
REQ-031 SHALL set all ready bits to 1 on flush, overriding allocates in the same cycle; the data array is untouched.
REQ-032 SHALL honour writes and reads during a flush cycle normally.

Reset
REQ-033 SHALL, on reset, clear every data entry to 0, set every ready bit to 1, clear rd_data to 0 and clear wr_conflict to 0.
REQ-034 SHALL, when reset is asserted mid-operation, discard in-flight reads; the first read after reset deasserts returns 0.

Structure
REQ-035 SHALL place the default DATA_W, NUM_PREGS and TAG_W constants and the ptag_t typedef in shared package core_pkg.
REQ-036 SHALL implement the ready-bit array in one sub-module, prf_scoreboard, which owns alloc, writeback, flush and query logic.
REQ-037 SHALL be synthesizable for any legal parameter set without code edits.

Verification
REQ-038 SHALL cover registered read: write 0xDEADBEEF to tag 5, read tag 5 next cycle -> rd_data=0xDEADBEEF one cycle after rd_en.
REQ-039 SHALL cover bypass: write 0x1234 to tag 9 and read tag 9 in the same cycle -> rd_data=0x1234 next cycle.
REQ-040 SHALL cover write conflict: ports 0/1 write 0xA/0xB to tag 7 in one cycle -> entry 7=0xB, wr_conflict=1 until reset.
REQ-041 SHALL cover tag 0: write 0xFFFF to tag 0 -> reads of tag 0 return 0 and rdy=1.
REQ-042 SHALL cover scoreboard: allocate tag 20 -> rdy=0; writeback tag 20 -> rdy=1 in that same cycle; allocate tag 21 then flush -> rdy(21)=1.
REQ-043 SHALL cover reset: assert reset mid-stream -> all rd_data=0, all rdy=1 and wr_conflict=0 immediately.
